// File: rtl/muldiv_iterative_pkg.sv
// rtl/muldiv_iterative_pkg.sv - shared op/state encodings and decode helpers for the RV32M unit
//
// Purpose: funct3 encodings of the RV32M ops, FSM state encoding and small
// decode helpers (signedness, div/rem classification) used by muldiv_iterative.
// Ports: none (package).

package muldiv_iterative_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Iteration counter value of the final RUN cycle (32 iterations, 0..31).
  localparam logic [4:0] LAST_COUNT = 5'd31;

  function automatic logic is_div(input op_e o);
    return o[2];
  endfunction

  // REM/REMU select the remainder; DIV/DIVU the quotient.
  function automatic logic is_rem(input op_e o);
    return o[2] & o[1];
  endfunction

  function automatic logic a_is_signed(input op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic b_is_signed(input op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iterative.sv
// rtl/muldiv_iterative.sv - iterative RV32M multiply/divide unit for the execute stage
//
// Purpose: multi-cycle MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Operands are
// converted to magnitudes, a 32-step shift-add (mul) or restoring
// shift-subtract (div) runs on one shared 64-bit shift register and one
// 33-bit adder/subtractor, then the sign is fixed up and the result written.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   start   - launch an op (sampled only in IDLE)
//   kill    - abandon the current op (pipeline flush)
//   op      - RV32M funct3
//   A, B    - rs1/rs2 operands, captured when start is accepted
//   busy    - high while an op is in flight (PREP..DONE)
//   done    - one-cycle pulse, result valid in the same cycle
//   result  - registered result, held until the next completed op

module muldiv_iterative
  import muldiv_iterative_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_iterative: only XLEN=32 is supported");
  end

  state_e            state, state_nxt;
  op_e               op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc;          // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   bmag;         // |B|: multiplicand or divisor
  logic [4:0]        cnt;
  logic              neg_q;
  logic              special_q;
  logic [XLEN-1:0]   special_val;

  // Operand preparation (used in PREP).
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              neg_res;

  always_comb begin
    a_neg    = a_is_signed(op_q) & a_q[XLEN-1];
    b_neg    = b_is_signed(op_q) & b_q[XLEN-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = is_div(op_q) && (b_q == '0);
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
               (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = is_rem(op_q) ? a_q : '1;
    end else begin
      special_res = is_rem(op_q) ? '0 : 32'h8000_0000;
    end
    // Remainder follows the dividend's sign; product and quotient are
    // negative when the operand signs differ.
    neg_res = is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
  end

  // Shared 33-bit adder/subtractor. For div, sum[33] is the no-borrow flag:
  // the shifted remainder is >= the divisor.
  logic              div_mode;
  logic [XLEN:0]     add_a, add_b;
  logic [XLEN+1:0]   sum;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    div_mode = is_div(op_q);
    add_a    = div_mode ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
    add_b    = {1'b0, bmag};
    sum      = {1'b0, add_a} + {1'b0, (div_mode ? ~add_b : add_b)} + {{(XLEN+1){1'b0}}, div_mode};
    acc_nxt  = acc;
    if (div_mode) begin
      if (sum[XLEN+1]) begin
        acc_nxt = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_nxt = {sum[XLEN:0], acc[XLEN-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[2*XLEN-1:1]};
      end
    end
  end

  // Sign fix and result select (used in DONE).
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, final_res;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    div_sel  = is_rem(op_q) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (special_q) begin
      final_res = special_val;
    end else if (div_mode) begin
      final_res = div_fix;
    end else if (op_q == OP_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start && !kill) state_nxt = S_PREP;
      S_PREP:  state_nxt = special ? S_DONE : S_RUN;
      S_RUN:   if (cnt == LAST_COUNT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      bmag        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      special_val <= '0;
      result      <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_q <= op_e'(op);
            a_q  <= A;
            b_q  <= B;
          end
        end
        S_PREP: begin
          if (!kill) begin
            acc         <= {{XLEN{1'b0}}, a_mag};
            bmag        <= b_mag;
            neg_q       <= neg_res;
            special_q   <= special;
            special_val <= special_res;
            cnt         <= '0;
          end
        end
        S_RUN: begin
          if (!kill) begin
            acc <= acc_nxt;
            cnt <= cnt + 5'd1;
          end
        end
        S_DONE: begin
          if (!kill) begin
            result <= final_res;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iterative.sv
// tb/tb_muldiv_iterative.sv - self-checking bench for muldiv_iterative against an arithmetic reference

module tb_muldiv_iterative;

  logic        clk;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] result;

  muldiv_iterative #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n++;

  typedef struct {
    int          acc;
    int          fin;
    logic [31:0] val;
    bit          killed;
  } ent_t;

  ent_t        q[$];
  int          free_edge = 0;
  int          n_acc = 0;
  logic [31:0] exp_result = '0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h edge=%0d", name, got, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0)) return 2;
    if (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Apply inputs for the next rising edge and advance the model accordingly.
  task automatic drive(input bit s, input bit k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int   nxt;
    ent_t e;
    start = s; kill = k; op = o; a_in = a; b_in = b;
    nxt = edge_n + 1;
    if (k) begin
      if (q.size() > 0) begin
        e = q[q.size()-1];
        if (!e.killed && e.acc < nxt && nxt <= e.fin) begin
          e.fin = nxt;
          e.killed = 1;
          q[q.size()-1] = e;
          free_edge = nxt + 1;
        end
      end
    end else if (s && nxt >= free_edge) begin
      e.acc = nxt;
      e.fin = nxt + ref_lat(o, a, b);
      e.val = ref_res(o, a, b);
      e.killed = 0;
      q.push_back(e);
      free_edge = e.fin + 1;
      n_acc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare of busy/done/result against the model.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      bit   e_b, e_d;
      ent_t f;
      e_b = 0;
      e_d = 0;
      if (q.size() > 0) begin
        f = q[0];
        e_b = (f.acc <= edge_n) && (edge_n < f.fin);
        if (!f.killed && edge_n == f.fin) begin
          e_d = 1;
          exp_result = f.val;
        end
        if (edge_n >= f.fin) void'(q.pop_front());
      end
      check("busy", {31'b0, busy}, {31'b0, e_b});
      check("done", {31'b0, done}, {31'b0, e_d});
      check("result", result, exp_result);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int lat_lit, input bit noise);
    int t0, lat;
    check("model_pin", ref_res(o, a, b), lit);
    drive(1, 0, o, a, b);
    t0 = edge_n + 1;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done) begin
        lat = edge_n - t0;
        break;
      end
      if (noise) drive(1'($urandom_range(0, 1)), 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      else drive(0, 0, 3'd0, 32'd0, 32'd0);
    end
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    check("latency", lat, lat_lit);
    check("direct_result", result, lit);
  endtask

  task automatic rand_operands(output logic [2:0] o, output logic [31:0] a, output logic [31:0] b);
    int sel;
    o = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
    sel = $urandom_range(0, 7);
    case (sel)
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: b = 32'($urandom_range(1, 9));
      3: a = 32'($urandom_range(0, 100));
      default: ;
    endcase
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int t0, target, guard;

    reset = 1'b1;
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    repeat (3) step();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    free_edge = edge_n + 1;
    mon_en = 1;
    step();

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op(3'd5, 32'd64, 32'd7, 32'd9, 34, 0);
    run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, 0);
    run_op(3'd7, 32'h1234, 32'd0, 32'h1234, 2, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);

    // Kill at RUN count 10: no done, result unchanged, then a fresh op.
    drive(1, 0, 3'd0, 32'd12345, 32'd6789);
    t0 = edge_n + 1;
    while (edge_n < t0 + 11) begin
      step();
      if (edge_n < t0 + 11) drive(0, 0, 3'd0, 32'd0, 32'd0);
    end
    drive(0, 1, 3'd0, 32'd0, 32'd0);
    step();
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_result", result, 32'd1);
    repeat (30) step();
    check("kill_no_done_result", result, 32'd1);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 34, 0);

    // Reset at RUN count 5 of a DIV.
    drive(1, 0, 3'd4, 32'd1000, 32'd7);
    t0 = edge_n + 1;
    while (edge_n < t0 + 6) begin
      step();
      if (edge_n < t0 + 6) drive(0, 0, 3'd0, 32'd0, 32'd0);
    end
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    reset = 1'b1;
    q.delete();
    exp_result = '0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    step();
    reset = 1'b0;
    free_edge = edge_n + 1;
    step();
    run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 34, 1);
    run_op(3'd7, 32'd1000, 32'd7, 32'd6, 34, 1);

    // Back-to-back random ops with start held high.
    target = n_acc + 1200;
    guard = 0;
    while (n_acc < target && guard < 1200 * 40) begin
      rand_operands(ro, ra, rb);
      drive(1, 0, ro, ra, rb);
      step();
      guard++;
    end
    check("random_ops_issued", n_acc, target);
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    repeat (40) step();

    // Random start/kill mix.
    for (int i = 0; i < 3000; i++) begin
      rand_operands(ro, ra, rb);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ro, ra, rb);
      step();
    end
    drive(0, 0, 3'd0, 32'd0, 32'd0);
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
